// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// slave = queue side, master = FetchStage2/Decode side.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

interface fetch_decode_queue_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1,
  parameter int DEPTH       = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                              flush_i;
  logic                              fs2Ready_i;
  logic [FETCH_WIDTH-1:0]            instValid_i;
  logic [FETCH_WIDTH-1:0][PKT_W-1:0] instPacket_i;
  logic                              decodeReady_i;
  logic [FETCH_WIDTH-1:0]            instValid_o;
  logic [FETCH_WIDTH-1:0][PKT_W-1:0] instPacket_o;
  logic                              stallFetch_o;
  logic [CW-1:0]                     count_o;
  logic                              overflowErr_o;

  modport slave (
    input  flush_i, fs2Ready_i, instValid_i, instPacket_i, decodeReady_i,
    output instValid_o, instPacket_o, stallFetch_o, count_o, overflowErr_o
  );

  modport master (
    output flush_i, fs2Ready_i, instValid_i, instPacket_i, decodeReady_i,
    input  instValid_o, instPacket_o, stallFetch_o, count_o, overflowErr_o
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Compacting circular instruction queue between FetchStage2 and Decode.
// Up to FETCH_WIDTH packets in and out per cycle; registered fetch stall.
`ifndef SIZE_INSTRUCTION
`define SIZE_INSTRUCTION 32
`endif
`ifndef SIZE_PC
`define SIZE_PC 32
`endif
`ifndef SIZE_CTI_LOG
`define SIZE_CTI_LOG 4
`endif

module fdq_wr_lane #(
  parameter int LANE        = 0,
  parameter int FETCH_WIDTH = 4,
  parameter int PW          = 4
) (
  input  logic                   en_i,
  input  logic [FETCH_WIDTH-1:0] mask_i,
  input  logic [PW-1:0]          tail_i,
  output logic                   we_o,
  output logic [PW-1:0]          addr_o
);
  logic [PW-1:0] off;

  // slot offset = number of valid lanes below this one
  always_comb begin
    off = '0;
    for (int j = 0; j < FETCH_WIDTH; j++)
      if (j < LANE) off = off + PW'(mask_i[j]);
  end

  assign addr_o = tail_i + off;
  assign we_o   = en_i & mask_i[LANE];
endmodule

module fetch_decode_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = `SIZE_INSTRUCTION + 2*`SIZE_PC + `SIZE_CTI_LOG + 1,
  parameter int DEPTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_decode_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d, n_enq, n_deq;
  logic             stall_q, stall_d, ovf_q;
  logic             enq_fire, drop;
  logic [FETCH_WIDTH-1:0]         we;
  logic [FETCH_WIDTH-1:0][PW-1:0] waddr;

  assign enq_fire = q.fs2Ready_i & ~stall_q & ~q.flush_i;
  assign drop     = q.fs2Ready_i & (|q.instValid_i) & stall_q;

  for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
    fdq_wr_lane #(.LANE(l), .FETCH_WIDTH(FETCH_WIDTH), .PW(PW)) u_wr (
      .en_i   (enq_fire),
      .mask_i (q.instValid_i),
      .tail_i (tail_q),
      .we_o   (we[l]),
      .addr_o (waddr[l])
    );
    assign q.instValid_o[l]  = count_q > CW'(l);
    assign q.instPacket_o[l] = mem[head_q + PW'(l)];
  end

  always_comb begin
    n_enq = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) n_enq = n_enq + CW'(q.instValid_i[i]);
    if (!enq_fire) n_enq = '0;
    n_deq = (count_q > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : count_q;
    if (!q.decodeReady_i) n_deq = '0;
    count_d = count_q + n_enq - n_deq;
    head_d  = head_q + n_deq[PW-1:0];
    tail_d  = tail_q + n_enq[PW-1:0];
    // conservative: stall whenever a full bundle might not fit next cycle
    stall_d = (CW'(DEPTH) - count_d) < CW'(FETCH_WIDTH);
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_WIDTH; l++)
      if (we[l]) mem[waddr[l]] <= q.instPacket_i[l];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (q.flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_q | drop;
    end
  end

  assign q.stallFetch_o  = stall_q;
  assign q.count_o       = count_q;
  assign q.overflowErr_o = ovf_q;
endmodule
